peak_dpu_lsu: RTL and testbench

- Load/store execution unit, directly downstream of the load/store decoder.
- Consumes the decoded ls op, base register value, immediate, store data and destination register.
- Computes the effective address, checks alignment, and runs one data-bus transaction with byte lanes.
- Sign/zero-extends load data and returns it to the register-file writeback port. Single outstanding access; non-pipelined.

---
 rtl/peak_dpu_pkg.sv | 45 ++++
 rtl/peak_dpu_lsu_align.sv | 41 ++++
 rtl/peak_dpu_lsu.sv | 191 +++++++++++++++++++
 tb/tb_peak_dpu_lsu.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/peak_dpu_pkg.sv
// Shared load/store definitions: op encodings (also used by the decoder), LSU state encoding
// and small op-decode helpers.
package peak_dpu_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4;
  localparam logic [2:0] SB  = 3'd5;
  localparam logic [2:0] SH  = 3'd6;
  localparam logic [2:0] SW  = 3'd7;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // MIS is the single cycle that presents a misaligned-access exception.
  typedef enum logic [1:0] {IDLE, REQ, WAIT, MIS} lsu_state_e;

  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      LB, LBU, SB: sz = SZ_B;
      LH, LHU, SH: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(input logic [2:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] ea_lo);
    logic bad;
    case (op_size(op))
      SZ_H:    bad = ea_lo[0];
      SZ_W:    bad = (ea_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/peak_dpu_lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, load lane extraction and extension.
// Purely combinational, no flow control.
module peak_dpu_lsu_align
  import peak_dpu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] lane;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    ldata_o = 32'h0;
    lane    = rdata_i >> {ea_lo_i, 3'b000};
    case (op_size(op_i))
      SZ_B: begin
        be_o    = 4'b0001 << ea_lo_i;
        wdata_o = {4{sdata_i[7:0]}};
        ldata_o = (op_i == LB) ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
      end
      SZ_H: begin
        be_o    = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{sdata_i[15:0]}};
        ldata_o = (op_i == LH) ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = sdata_i;
        ldata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/peak_dpu_lsu.sv
// Load/store unit: one non-pipelined data-bus access per op; earliest writeback 3 cycles after accept.
// ls_rdy is high only in IDLE; bus request held stable until dbus_gnt.
module peak_dpu_lsu #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_vld,
  output logic        ls_rdy,
  input  logic [2:0]  ls_op,
  input  logic [31:0] ls_base,
  input  logic [31:0] ls_imm,
  input  logic [31:0] ls_sdata,
  input  logic [4:0]  ls_wr_addr,
  input  logic        flush,
  output logic        dbus_req,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic        wb_vld,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        exc_misalign,
  output logic        exc_buserr,
  output logic [31:0] exc_addr
);
  import peak_dpu_pkg::*;

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  lsu_state_e  state_q, state_d;
  logic [31:0] ea_q, ea_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] sdata_q, sdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        flushed_q, flushed_d;
  logic        wb_vld_q, wb_vld_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        st_done_q, st_done_d;
  logic        exc_buserr_q, exc_buserr_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        accept, timeout, suppress;
  logic [31:0] ea_in;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;

  assign ea_in   = ls_base + ls_imm;
  assign ls_rdy  = (state_q == IDLE);
  assign accept  = ls_vld && ls_rdy && !flush;
  assign timeout = (WAIT_MAX != 0) && (cnt_q == CW'(WAIT_MAX - 1));
  // A flush seen at any point after the grant kills the architectural result, not the bus beat.
  assign suppress = flushed_q || flush;

  peak_dpu_lsu_align u_align (
    .op_i    (op_q),
    .ea_lo_i (ea_q[1:0]),
    .sdata_i (sdata_q),
    .rdata_i (dbus_rdata),
    .be_o    (be),
    .wdata_o (wdata),
    .ldata_o (ldata)
  );

  assign dbus_req     = (state_q == REQ);
  assign dbus_addr    = {ea_q[31:2], 2'b00};
  assign dbus_we      = dbus_req && op_is_store(op_q);
  assign dbus_be      = dbus_req ? be : 4'b0000;
  assign dbus_wdata   = wdata;
  assign exc_misalign = (state_q == MIS) && !flush;
  assign wb_vld       = wb_vld_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign st_done      = st_done_q;
  assign exc_buserr   = exc_buserr_q;
  assign exc_addr     = exc_addr_q;

  always_comb begin
    state_d      = state_q;
    ea_d         = ea_q;
    op_d         = op_q;
    rd_d         = rd_q;
    sdata_d      = sdata_q;
    cnt_d        = cnt_q;
    flushed_d    = flushed_q;
    wb_vld_d     = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    st_done_d    = 1'b0;
    exc_buserr_d = 1'b0;
    exc_addr_d   = exc_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          ea_d      = ea_in;
          op_d      = ls_op;
          rd_d      = ls_wr_addr;
          sdata_d   = ls_sdata;
          cnt_d     = '0;
          flushed_d = 1'b0;
          if (op_misaligned(ls_op, ea_in[1:0])) begin
            exc_addr_d = ea_in;
            state_d    = MIS;
          end else begin
            state_d = REQ;
          end
        end
      end
      MIS: state_d = IDLE;
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (flush && !dbus_gnt) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d      = IDLE;
          exc_buserr_d = !suppress;
          exc_addr_d   = ea_q;
        end else if (dbus_gnt) begin
          state_d   = WAIT;
          flushed_d = flushed_q || flush;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (dbus_rvalid) begin
          state_d = IDLE;
          if (!suppress) begin
            if (dbus_err) begin
              exc_buserr_d = 1'b1;
              exc_addr_d   = ea_q;
            end else if (op_is_store(op_q)) begin
              st_done_d = 1'b1;
            end else if (rd_q != 5'd0) begin
              wb_vld_d  = 1'b1;
              wb_addr_d = rd_q;
              wb_data_d = ldata;
            end
          end
        end else if (timeout) begin
          state_d      = IDLE;
          exc_buserr_d = !suppress;
          exc_addr_d   = ea_q;
        end else begin
          flushed_d = flushed_q || flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ea_q         <= 32'h0;
      op_q         <= 3'd0;
      rd_q         <= 5'd0;
      sdata_q      <= 32'h0;
      cnt_q        <= '0;
      flushed_q    <= 1'b0;
      wb_vld_q     <= 1'b0;
      wb_addr_q    <= 5'd0;
      wb_data_q    <= 32'h0;
      st_done_q    <= 1'b0;
      exc_buserr_q <= 1'b0;
      exc_addr_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      ea_q         <= ea_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      sdata_q      <= sdata_d;
      cnt_q        <= cnt_d;
      flushed_q    <= flushed_d;
      wb_vld_q     <= wb_vld_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      st_done_q    <= st_done_d;
      exc_buserr_q <= exc_buserr_d;
      exc_addr_q   <= exc_addr_d;
    end
  end

endmodule

// File: tb/tb_peak_dpu_lsu.sv
// Directed bench for peak_dpu_lsu with WAIT_MAX=8; bus responses are driven cycle by cycle.
module tb_peak_dpu_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_vld = 1'b0;
  logic        ls_rdy;
  logic [2:0]  ls_op = 3'd0;
  logic [31:0] ls_base = 32'h0;
  logic [31:0] ls_imm = 32'h0;
  logic [31:0] ls_sdata = 32'h0;
  logic [4:0]  ls_wr_addr = 5'd0;
  logic        flush = 1'b0;
  logic        dbus_req;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt = 1'b0;
  logic        dbus_rvalid = 1'b0;
  logic [31:0] dbus_rdata = 32'h0;
  logic        dbus_err = 1'b0;
  logic        wb_vld;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        st_done;
  logic        exc_misalign;
  logic        exc_buserr;
  logic [31:0] exc_addr;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2, OP_LBU = 3'd3;
  localparam logic [2:0] OP_SH = 3'd6, OP_SW = 3'd7;

  peak_dpu_lsu #(.WAIT_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_op(ls_op),
    .ls_base(ls_base), .ls_imm(ls_imm), .ls_sdata(ls_sdata), .ls_wr_addr(ls_wr_addr),
    .flush(flush), .dbus_req(dbus_req), .dbus_addr(dbus_addr), .dbus_we(dbus_we),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data), .st_done(st_done),
    .exc_misalign(exc_misalign), .exc_buserr(exc_buserr), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] sdata, input logic [4:0] rd);
    ls_vld = 1'b1; ls_op = op; ls_base = base; ls_imm = imm; ls_sdata = sdata; ls_wr_addr = rd;
    tick();
    ls_vld = 1'b0;
  endtask

  // Runs one aligned access; returns in the cycle where wb_vld/st_done/exc_buserr should pulse.
  task automatic access(input string tg, input logic [2:0] op, input logic [31:0] base,
                        input logic [31:0] imm, input logic [31:0] sdata, input logic [4:0] rd,
                        input int gdly, input logic [31:0] rdata, input logic err,
                        input logic [3:0] xbe, input logic [31:0] xwd);
    logic [31:0] ea;
    logic        st;
    ea = base + imm;
    st = (op >= 3'd5);
    issue(op, base, imm, sdata, rd);
    for (int i = 0; i <= gdly; i++) begin
      chk({tg, ".req"}, {31'h0, dbus_req}, 32'h1);
      chk({tg, ".addr"}, dbus_addr, {ea[31:2], 2'b00});
      chk({tg, ".be"}, {28'h0, dbus_be}, {28'h0, xbe});
      chk({tg, ".we"}, {31'h0, dbus_we}, {31'h0, st});
      if (st) chk({tg, ".wdata"}, dbus_wdata, xwd);
      if (i == gdly) dbus_gnt = 1'b1;
      tick();
    end
    dbus_gnt = 1'b0;
    chk({tg, ".req_drop"}, {31'h0, dbus_req}, 32'h0);
    dbus_rvalid = 1'b1; dbus_rdata = rdata; dbus_err = err;
    tick();
    dbus_rvalid = 1'b0; dbus_err = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst.ls_rdy", {31'h0, ls_rdy}, 32'h1);
    chk("rst.req", {31'h0, dbus_req}, 32'h0);
    chk("rst.be", {28'h0, dbus_be}, 32'h0);
    chk("rst.addr", dbus_addr, 32'h0);
    chk("rst.wdata", dbus_wdata, 32'h0);
    chk("rst.pulses", {28'h0, wb_vld, st_done, exc_misalign, exc_buserr}, 32'h0);
    chk("rst.wb_data", wb_data, 32'h0);
    chk("rst.exc_addr", exc_addr, 32'h0);
    rst_n = 1'b1;
    tick();

    // LW, minimum latency: req T+1 / gnt T+1 / rvalid T+2 / wb T+3
    access("lw", OP_LW, 32'h1000, 32'h4, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0);
    chk("lw.wb_vld", {31'h0, wb_vld}, 32'h1);
    chk("lw.wb_addr", {27'h0, wb_addr}, 32'd5);
    chk("lw.wb_data", wb_data, 32'hDEADBEEF);
    chk("lw.ls_rdy", {31'h0, ls_rdy}, 32'h1);
    tick();
    chk("lw.wb_pulse_end", {31'h0, wb_vld}, 32'h0);

    access("lb", OP_LB, 32'h2000, 32'h3, 32'h0, 5'd7, 0, 32'h80000000, 1'b0, 4'b1000, 32'h0);
    chk("lb.wb_data", wb_data, 32'hFFFFFF80);
    chk("lb.wb_vld", {31'h0, wb_vld}, 32'h1);
    access("lbu", OP_LBU, 32'h2000, 32'h3, 32'h0, 5'd7, 0, 32'h80000000, 1'b0, 4'b1000, 32'h0);
    chk("lbu.wb_data", wb_data, 32'h00000080);

    // LH from upper half, negative value
    access("lh", OP_LH, 32'h2000, 32'h2, 32'h0, 5'd8, 1, 32'h9ABC0000, 1'b0, 4'b1100, 32'h0);
    chk("lh.wb_data", wb_data, 32'hFFFF9ABC);

    // SH with grant held off 3 cycles: request stable for 4 cycles
    access("sh", OP_SH, 32'h3000, 32'h2, 32'h1234ABCD, 5'd0, 3, 32'h0, 1'b0, 4'b1100, 32'hABCDABCD);
    chk("sh.st_done", {31'h0, st_done}, 32'h1);
    chk("sh.wb_vld", {31'h0, wb_vld}, 32'h0);
    tick();
    chk("sh.st_done_end", {31'h0, st_done}, 32'h0);

    // Misaligned LW: no request, one-cycle exception
    issue(OP_LW, 32'h1000, 32'h1, 32'h0, 5'd4);
    chk("mis.req", {31'h0, dbus_req}, 32'h0);
    chk("mis.exc", {31'h0, exc_misalign}, 32'h1);
    chk("mis.exc_addr", exc_addr, 32'h1001);
    tick();
    chk("mis.exc_end", {31'h0, exc_misalign}, 32'h0);
    chk("mis.ls_rdy", {31'h0, ls_rdy}, 32'h1);

    // Flush in the misalign cycle suppresses the exception
    issue(OP_SW, 32'h2000, 32'h2, 32'h0, 5'd0);
    flush = 1'b1;
    #1;
    chk("misfl.exc", {31'h0, exc_misalign}, 32'h0);
    tick();
    flush = 1'b0;

    // Timeout: 8 cycles in REQ/WAIT allowed, exc_buserr in the following cycle
    issue(OP_LW, 32'h0, 32'h40, 32'h0, 5'd3);
    for (int i = 1; i <= 8; i++) begin
      chk("to.no_exc_yet", {31'h0, exc_buserr}, 32'h0);
      tick();
    end
    chk("to.exc", {31'h0, exc_buserr}, 32'h1);
    chk("to.exc_addr", exc_addr, 32'h40);
    chk("to.req", {31'h0, dbus_req}, 32'h0);
    chk("to.ls_rdy", {31'h0, ls_rdy}, 32'h1);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h12345678;
    tick();
    dbus_rvalid = 1'b0;
    chk("to.stray", {28'h0, wb_vld, st_done, exc_misalign, exc_buserr}, 32'h0);

    // Bus error response
    access("err", OP_LH, 32'h10, 32'h0, 32'h0, 5'd9, 0, 32'h5555AAAA, 1'b1, 4'b0011, 32'h0);
    chk("err.exc", {31'h0, exc_buserr}, 32'h1);
    chk("err.exc_addr", exc_addr, 32'h10);
    chk("err.wb_vld", {31'h0, wb_vld}, 32'h0);

    // Load to x0 runs on the bus but does not write back
    access("x0", OP_LW, 32'h100, 32'h0, 32'h0, 5'd0, 0, 32'hCAFEF00D, 1'b0, 4'b1111, 32'h0);
    chk("x0.wb_vld", {30'h0, wb_vld, exc_buserr}, 32'h0);

    // Flush together with ls_vld blocks acceptance
    ls_vld = 1'b1; ls_op = OP_SW; ls_base = 32'h50; ls_imm = 32'h0; flush = 1'b1;
    tick();
    ls_vld = 1'b0; flush = 1'b0;
    chk("flacc.req", {31'h0, dbus_req}, 32'h0);
    chk("flacc.ls_rdy", {31'h0, ls_rdy}, 32'h1);

    // Flush in REQ before grant drops the request
    issue(OP_SW, 32'h50, 32'h0, 32'h11112222, 5'd0);
    chk("flreq.req_before", {31'h0, dbus_req}, 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flreq.req", {31'h0, dbus_req}, 32'h0);
    chk("flreq.ls_rdy", {31'h0, ls_rdy}, 32'h1);
    tick();
    chk("flreq.quiet", {28'h0, wb_vld, st_done, exc_misalign, exc_buserr}, 32'h0);

    // Flush in WAIT: response consumed, writeback suppressed
    issue(OP_LW, 32'h200, 32'h0, 32'h0, 5'd6);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h0BADBEEF;
    tick();
    dbus_rvalid = 1'b0;
    chk("flwait.wb_vld", {31'h0, wb_vld}, 32'h0);
    chk("flwait.ls_rdy", {31'h0, ls_rdy}, 32'h1);

    // Reset mid-WAIT clears everything immediately
    issue(OP_LW, 32'h300, 32'h4, 32'h0, 5'd2);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstw.req", {31'h0, dbus_req}, 32'h0);
    chk("rstw.addr", dbus_addr, 32'h0);
    chk("rstw.pulses", {28'h0, wb_vld, st_done, exc_misalign, exc_buserr}, 32'h0);
    chk("rstw.wb_data", wb_data, 32'h0);
    chk("rstw.exc_addr", exc_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstw.ls_rdy", {31'h0, ls_rdy}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
